// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Request/response handshake between the microcoded control path and the LSU,
// plus the LSU's port onto the synchronous byte-enabled data SRAM.
//   slave  : the view the LSU takes of this bundle
//   master : the view of the environment (control path + SRAM)
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int MEM_ADDR_WIDTH = 4
);
  // request channel from the control path
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [2:0]                req_funct3;
  logic [31:0]               req_addr;
  logic [31:0]               req_wdata;

  // response channel, a single-cycle pulse with no back-pressure
  logic                      rsp_valid;
  logic [31:0]               rsp_data;
  logic                      rsp_err;

  // data SRAM port
  logic                      mem_en;
  logic                      mem_r;
  logic                      mem_w;
  logic [MEM_ADDR_WIDTH-1:0] mem_r_addr;
  logic [MEM_ADDR_WIDTH-1:0] mem_w_addr;
  logic [3:0]                mem_byte_en;
  logic [31:0]               mem_in;
  logic [31:0]               mem_out;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_out,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           mem_en, mem_r, mem_w, mem_r_addr, mem_w_addr, mem_byte_en, mem_in
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           mem_en, mem_r, mem_w, mem_r_addr, mem_w_addr, mem_byte_en, mem_in
  );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// RV32 load/store front end for a synchronous byte-enabled data SRAM.
// One request at a time; one response pulse per request. Byte addresses are
// folded onto SRAM word addresses (upper bits alias), store data is shifted
// into its byte lanes and load data is aligned and sign/zero-extended.
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   undefined : misaligned H/W accesses are rejected with rsp_err
//   defined   : misaligned accesses become two back-to-back SRAM accesses
//               (word A lanes off..3, then word A+1 the remaining low lanes)
//
// XLEN must be 32 (four byte lanes). READ_LATENCY is 1 for an SRAM with a
// registered output and 0 for a fall-through read port.
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int MEM_ADDR_WIDTH = 4,
  parameter int READ_LATENCY   = 1
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam logic [AW-1:0] WORD_ONE = {{(AW-1){1'b0}}, 1'b1};

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    SPLIT2  = 2'd2,
    RSP     = 2'd3
  } state_t;

  // Byte-lane mask over two consecutive words; bits [7:4] are the spill
  // into the following word for a misaligned access.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  // Store data placed on the byte lanes of two consecutive words.
  function automatic logic [63:0] lane_data(input logic [31:0] data, input logic [1:0] off);
    return {32'h0, data} << {off, 3'b000};
  endfunction

  // Pick the addressed bytes out of two consecutive words and extend them.
  function automatic logic [31:0] extend_load(input logic [63:0] raw, input logic [1:0] off,
                                              input logic [2:0] funct3);
    logic [31:0] lanes;
    logic [31:0] result;
    lanes = 32'(raw >> {off, 3'b000});
    case (funct3[1:0])
      2'd0:    result = funct3[2] ? {24'h0, lanes[7:0]}  : {{24{lanes[7]}},  lanes[7:0]};
      2'd1:    result = funct3[2] ? {16'h0, lanes[15:0]} : {{16{lanes[15]}}, lanes[15:0]};
      default: result = lanes;
    endcase
    return result;
  endfunction

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [AW-1:0]     word_q;
  logic              split_q;
  logic [3:0]        split_be_q;
  logic [31:0]       split_in_q;
  logic [31:0]       lo_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic              rsp_err_q;

  logic              req_ready_c;
  logic              accept;
  logic [1:0]        size_c;
  logic [1:0]        off_c;
  logic [AW-1:0]     word_c;
  logic [7:0]        mask_c;
  logic [63:0]       wide_c;
  logic              illegal_c;
  logic              misalign_c;
  logic              unused_addr;

  logic              en_c, r_c, w_c;
  logic [AW-1:0]     addr_c;
  logic [3:0]        be_c;
  logic [31:0]       min_c;
  logic              lo_load;
  logic              rsp_data_load;
  logic [XLEN-1:0]   rsp_data_d;
  logic              rsp_err_load;
  logic              rsp_err_d;

  assign size_c      = bus.req_funct3[1:0];
  assign off_c       = bus.req_addr[1:0];
  assign word_c      = bus.req_addr[AW+1:2];
  assign unused_addr = ^bus.req_addr[31:AW+2];
  assign mask_c      = lane_mask(size_c, off_c);
  assign wide_c      = lane_data(bus.req_wdata, off_c);
  assign misalign_c  = |mask_c[7:4];
  assign illegal_c   = (size_c == 2'd3) ||
                       (bus.req_we && bus.req_funct3[2]) ||
                       (!bus.req_we && (size_c == 2'd2) && bus.req_funct3[2]);

  assign req_ready_c = (state_q == IDLE) && rst_n;
  assign accept      = bus.req_valid && req_ready_c;

  // Next-state logic and SRAM strobes; the first access is issued
  // combinationally in the handshake cycle, the split access from SPLIT2.
  always_comb begin
    state_d       = state_q;
    en_c          = 1'b0;
    r_c           = 1'b0;
    w_c           = 1'b0;
    addr_c        = word_c;
    be_c          = 4'h0;
    min_c         = 32'h0;
    lo_load       = 1'b0;
    rsp_data_load = 1'b0;
    rsp_data_d    = '0;
    rsp_err_load  = 1'b0;
    rsp_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_data_load = 1'b1;
          rsp_err_load  = 1'b1;
          if (illegal_c || (misalign_c && !SPLIT_EN)) begin
            rsp_err_d = 1'b1;
            state_d   = RSP;
          end else begin
            en_c  = 1'b1;
            r_c   = !bus.req_we;
            w_c   = bus.req_we;
            be_c  = bus.req_we ? mask_c[3:0] : 4'h0;
            min_c = bus.req_we ? wide_c[31:0] : 32'h0;
            if (misalign_c) begin
              lo_load = !bus.req_we && (READ_LATENCY == 0);
              state_d = SPLIT2;
            end else if (bus.req_we) begin
              state_d = RSP;
            end else if (READ_LATENCY == 0) begin
              rsp_data_d = extend_load({32'h0, bus.mem_out}, off_c, bus.req_funct3);
              state_d    = RSP;
            end else begin
              state_d = WAIT_RD;
            end
          end
        end
      end
      SPLIT2: begin
        en_c   = 1'b1;
        r_c    = !we_q;
        w_c    = we_q;
        addr_c = word_q + WORD_ONE;
        be_c   = we_q ? split_be_q : 4'h0;
        min_c  = we_q ? split_in_q : 32'h0;
        if (we_q) begin
          state_d = RSP;
        end else if (READ_LATENCY == 0) begin
          rsp_data_load = 1'b1;
          rsp_data_d    = extend_load({bus.mem_out, lo_q}, off_q, funct3_q);
          state_d       = RSP;
        end else begin
          lo_load = 1'b1;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        rsp_data_load = 1'b1;
        rsp_data_d    = extend_load(split_q ? {bus.mem_out, lo_q} : {32'h0, bus.mem_out},
                                    off_q, funct3_q);
        state_d       = RSP;
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus the request fields and read data held across the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'h0;
      off_q      <= 2'h0;
      word_q     <= '0;
      split_q    <= 1'b0;
      split_be_q <= 4'h0;
      split_in_q <= 32'h0;
      lo_q       <= 32'h0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q       <= bus.req_we;
        funct3_q   <= bus.req_funct3;
        off_q      <= off_c;
        word_q     <= word_c;
        split_q    <= misalign_c;
        split_be_q <= mask_c[7:4];
        split_in_q <= wide_c[63:32];
      end
      if (lo_load) begin
        lo_q <= bus.mem_out;
      end
      if (rsp_data_load) begin
        rsp_data_q <= rsp_data_d;
      end
      if (rsp_err_load) begin
        rsp_err_q <= rsp_err_d;
      end
    end
  end

  assign bus.req_ready   = req_ready_c;
  assign bus.rsp_valid   = (state_q == RSP);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.mem_en      = en_c && rst_n;
  assign bus.mem_r       = r_c && rst_n;
  assign bus.mem_w       = w_c && rst_n;
  assign bus.mem_r_addr  = addr_c;
  assign bus.mem_w_addr  = addr_c;
  assign bus.mem_byte_en = be_c & {4{rst_n}};
  assign bus.mem_in      = min_c;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit. Two instances share clock and reset:
// dut (registered SRAM, READ_LATENCY=1) and dut0 (fall-through, READ_LATENCY=0),
// each attached to a small behavioural SRAM. Expectations for misaligned
// accesses follow LSU_MISALIGN_SPLIT_EN as the design is built.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n;

  load_store_unit_if #(.MEM_ADDR_WIDTH(AW)) bus ();
  load_store_unit_if #(.MEM_ADDR_WIDTH(AW)) bus0 ();

  load_store_unit #(.XLEN(32), .MEM_ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  load_store_unit #(.XLEN(32), .MEM_ADDR_WIDTH(AW), .READ_LATENCY(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  // free-running 10-unit clock
  always #5 clk = ~clk;

  logic [31:0]   sram1 [16];
  logic [31:0]   sram0 [16];
  logic [31:0]   rdata1;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;
  int            en_count;
  int            rd_count;

  // registered-output SRAM behind dut, with a backdoor preload port
  always @(posedge clk) begin
    if (bd_we) begin
      sram1[bd_addr] <= bd_data;
    end else if (bus.mem_en && bus.mem_w) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_byte_en[b]) sram1[bus.mem_w_addr][8*b +: 8] <= bus.mem_in[8*b +: 8];
      end
    end
    if (bus.mem_en && bus.mem_r) rdata1 <= sram1[bus.mem_r_addr];
  end
  assign bus.mem_out = rdata1;

  // fall-through SRAM behind dut0
  always @(posedge clk) begin
    if (bd_we) begin
      sram0[bd_addr] <= bd_data;
    end else if (bus0.mem_en && bus0.mem_w) begin
      for (int b = 0; b < 4; b++) begin
        if (bus0.mem_byte_en[b]) sram0[bus0.mem_w_addr][8*b +: 8] <= bus0.mem_in[8*b +: 8];
      end
    end
  end
  assign bus0.mem_out = sram0[bus0.mem_r_addr];

  // count SRAM activity of dut so a whole transaction can be checked for strobes
  always @(posedge clk) begin
    if (bus.mem_en) en_count <= en_count + 1;
    if (bus.mem_en && bus.mem_r) rd_count <= rd_count + 1;
  end

  int compare_count = 0;
  int mismatch_count = 0;

  logic          a1_en, a1_r, a1_w, a2_en, a2_r, a2_w;
  logic [AW-1:0] a1_raddr, a1_waddr, a2_raddr, a2_waddr;
  logic [3:0]    a1_be, a2_be;
  logic [31:0]   a1_in, a2_in;
  int            rsp_lat;
  logic [31:0]   rsp_data_got;
  logic          rsp_err_got;
  int            rl0_lat;
  logic [31:0]   rl0_data;
  logic          rl0_err;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge with dut idle: presents one request, snapshots the
  // accept-cycle and following-cycle SRAM strobes, measures response latency.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    #1;
    a1_en = bus.mem_en; a1_r = bus.mem_r; a1_w = bus.mem_w;
    a1_raddr = bus.mem_r_addr; a1_waddr = bus.mem_w_addr;
    a1_be = bus.mem_byte_en; a1_in = bus.mem_in;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    a2_en = bus.mem_en; a2_r = bus.mem_r; a2_w = bus.mem_w;
    a2_raddr = bus.mem_r_addr; a2_waddr = bus.mem_w_addr;
    a2_be = bus.mem_byte_en; a2_in = bus.mem_in;
    rsp_lat = 0; rsp_data_got = 32'h0; rsp_err_got = 1'b0;
    for (int i = 1; i <= 6 && rsp_lat == 0; i++) begin
      if (bus.rsp_valid) begin
        rsp_lat = i; rsp_data_got = bus.rsp_data; rsp_err_got = bus.rsp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    checkOutput("rsp_single_pulse", 32'(bus.rsp_valid), 0);
    @(negedge clk);
  endtask

  // Same handshake on the fall-through instance, response only.
  task automatic applyStimulusRl0(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd);
    bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_funct3 = f3;
    bus0.req_addr = addr; bus0.req_wdata = wd;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    rl0_lat = 0; rl0_data = 32'h0; rl0_err = 1'b0;
    for (int i = 1; i <= 6 && rl0_lat == 0; i++) begin
      if (bus0.rsp_valid) begin
        rl0_lat = i; rl0_data = bus0.rsp_data; rl0_err = bus0.rsp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    @(negedge clk);
  endtask

  // hard stop in case something never settles
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int  en_before;
  int  rd_before;
  logic saw_rsp;

  // directed sequence
  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'h0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = 3'h0;
    bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
    bd_we = 1'b0; bd_addr = '0; bd_data = 32'h0;
    rst_n = 1'b0;

    // reset: outputs quiet even with a request presented
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    #1;
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    checkOutput("reset_rsp_data", bus.rsp_data, 32'h0);
    checkOutput("reset_rsp_err", 32'(bus.rsp_err), 0);
    checkOutput("reset_mem_en", 32'(bus.mem_en), 0);
    checkOutput("reset_mem_w", 32'(bus.mem_w), 0);
    checkOutput("reset_byte_en", 32'(bus.mem_byte_en), 0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", 32'(bus.req_ready), 1);
    @(negedge clk);

    // 1. SW 0xDEADBEEF @0x8
    applyStimulus(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    checkOutput("sw_en", 32'(a1_en), 1);
    checkOutput("sw_w", 32'(a1_w), 1);
    checkOutput("sw_waddr", 32'(a1_waddr), 2);
    checkOutput("sw_be", 32'(a1_be), 32'hF);
    checkOutput("sw_in", a1_in, 32'hDEADBEEF);
    checkOutput("sw_lat", 32'(rsp_lat), 1);
    checkOutput("sw_err", 32'(rsp_err_got), 0);
    checkOutput("sw_data", rsp_data_got, 32'h0);
    // LW @0x48 aliases onto word 2
    applyStimulus(1'b0, 3'b010, 32'h48, 32'h0);
    checkOutput("lw_alias_raddr", 32'(a1_raddr), 2);
    checkOutput("lw_alias_r", 32'(a1_r), 1);
    checkOutput("lw_alias_be", 32'(a1_be), 0);
    checkOutput("lw_alias_data", rsp_data_got, 32'hDEADBEEF);
    checkOutput("lw_alias_lat", 32'(rsp_lat), 2);

    // 2. byte store/load with sign and zero extension
    applyStimulus(1'b1, 3'b000, 32'h0D, 32'h0000005A);
    checkOutput("sb5a_waddr", 32'(a1_waddr), 3);
    checkOutput("sb5a_be", 32'(a1_be), 32'h2);
    checkOutput("sb5a_in", a1_in, 32'h00005A00);
    checkOutput("sb5a_lat", 32'(rsp_lat), 1);
    applyStimulus(1'b0, 3'b000, 32'h0D, 32'h0);
    checkOutput("lb5a_raddr", 32'(a1_raddr), 3);
    checkOutput("lb5a_data", rsp_data_got, 32'h0000005A);
    applyStimulus(1'b1, 3'b000, 32'h0D, 32'h000000A5);
    checkOutput("sba5_in", a1_in, 32'h0000A500);
    applyStimulus(1'b0, 3'b000, 32'h0D, 32'h0);
    checkOutput("lba5_data", rsp_data_got, 32'hFFFFFFA5);
    applyStimulus(1'b0, 3'b100, 32'h0D, 32'h0);
    checkOutput("lbua5_data", rsp_data_got, 32'h000000A5);

    // 3. LH / LHU @0x6 on both read latencies
    preload(4'd1, 32'h80011234);
    applyStimulus(1'b0, 3'b001, 32'h6, 32'h0);
    checkOutput("lh6_data", rsp_data_got, 32'hFFFF8001);
    checkOutput("lh6_lat", 32'(rsp_lat), 2);
    applyStimulus(1'b0, 3'b101, 32'h6, 32'h0);
    checkOutput("lhu6_data", rsp_data_got, 32'h00008001);
    applyStimulusRl0(1'b0, 3'b001, 32'h6, 32'h0);
    checkOutput("rl0_lh6_data", rl0_data, 32'hFFFF8001);
    checkOutput("rl0_lh6_lat", 32'(rl0_lat), 1);
    applyStimulusRl0(1'b0, 3'b100, 32'h5, 32'h0);
    checkOutput("rl0_lbu5_data", rl0_data, 32'h00000012);

    // 4. misaligned LW @0x5 and LH @0x7
    preload(4'd1, 32'h44332211);
    preload(4'd2, 32'h88776655);
    en_before = en_count; rd_before = rd_count;
    applyStimulus(1'b0, 3'b010, 32'h5, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    checkOutput("lw5_data", rsp_data_got, 32'h55443322);
    checkOutput("lw5_err", 32'(rsp_err_got), 0);
    checkOutput("lw5_lat", 32'(rsp_lat), 3);
    checkOutput("lw5_reads", 32'(rd_count - rd_before), 2);
    checkOutput("lw5_raddr1", 32'(a1_raddr), 1);
    checkOutput("lw5_raddr2", 32'(a2_raddr), 2);
    checkOutput("lw5_r2", 32'(a2_r), 1);
    applyStimulusRl0(1'b0, 3'b010, 32'h5, 32'h0);
    checkOutput("rl0_lw5_data", rl0_data, 32'h55443322);
    checkOutput("rl0_lw5_lat", 32'(rl0_lat), 2);
    applyStimulus(1'b0, 3'b001, 32'h7, 32'h0);
    checkOutput("lh7_data", rsp_data_got, 32'h00005544);
    checkOutput("lh7_lat", 32'(rsp_lat), 3);
`else
    checkOutput("lw5_err", 32'(rsp_err_got), 1);
    checkOutput("lw5_data", rsp_data_got, 32'h0);
    checkOutput("lw5_lat", 32'(rsp_lat), 1);
    checkOutput("lw5_no_strobe", 32'(en_count - en_before), 0);
    applyStimulus(1'b0, 3'b001, 32'h7, 32'h0);
    checkOutput("lh7_err", 32'(rsp_err_got), 1);
    checkOutput("lh7_en", 32'(a1_en), 0);
`endif

    // 5. SW 0x11223344 @0x3F wraps from word 15 to word 0
    applyStimulus(1'b1, 3'b010, 32'h3F, 32'h11223344);
`ifdef LSU_MISALIGN_SPLIT_EN
    checkOutput("sw3f_waddr1", 32'(a1_waddr), 15);
    checkOutput("sw3f_be1", 32'(a1_be), 32'h8);
    checkOutput("sw3f_in1", a1_in, 32'h44000000);
    checkOutput("sw3f_waddr2", 32'(a2_waddr), 0);
    checkOutput("sw3f_be2", 32'(a2_be), 32'h7);
    checkOutput("sw3f_in2", a2_in, 32'h00112233);
    checkOutput("sw3f_w2", 32'(a2_w), 1);
    checkOutput("sw3f_lat", 32'(rsp_lat), 2);
    checkOutput("sw3f_err", 32'(rsp_err_got), 0);
    applyStimulus(1'b0, 3'b010, 32'h3F, 32'h0);
    checkOutput("lw3f_data", rsp_data_got, 32'h11223344);
`else
    checkOutput("sw3f_err", 32'(rsp_err_got), 1);
    checkOutput("sw3f_en", 32'(a1_en), 0);
    checkOutput("sw3f_lat", 32'(rsp_lat), 1);
`endif

    // illegal encodings: unsigned store, LWU
    applyStimulus(1'b1, 3'b100, 32'h0, 32'h12345678);
    checkOutput("sbu_err", 32'(rsp_err_got), 1);
    checkOutput("sbu_en", 32'(a1_en), 0);
    applyStimulus(1'b0, 3'b110, 32'h0, 32'h0);
    checkOutput("lwu_err", 32'(rsp_err_got), 1);
    checkOutput("lwu_lat", 32'(rsp_lat), 1);

    // 6. reset while a load waits for SRAM data
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h8;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    saw_rsp = 1'b0;
    checkOutput("midrst_mem_en", 32'(bus.mem_en), 0);
    repeat (2) begin
      @(posedge clk); #1;
      saw_rsp = saw_rsp | bus.rsp_valid;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_ready", 32'(bus.req_ready), 1);
    repeat (3) begin
      @(posedge clk); #1;
      saw_rsp = saw_rsp | bus.rsp_valid;
    end
    checkOutput("midrst_no_rsp", 32'(saw_rsp), 0);
    @(negedge clk);
    applyStimulus(1'b1, 3'b010, 32'h0, 32'hCAFEF00D);
    checkOutput("post_rst_sw_lat", 32'(rsp_lat), 1);
    checkOutput("post_rst_sw_err", 32'(rsp_err_got), 0);
    checkOutput("post_rst_sw_be", 32'(a1_be), 32'hF);
    checkOutput("post_rst_sw_mem", sram1[0], 32'hCAFEF00D);
    applyStimulus(1'b0, 3'b011, 32'h0, 32'h0);
    checkOutput("funct3_3_err", 32'(rsp_err_got), 1);
    checkOutput("funct3_3_data", rsp_data_got, 32'h0);
    checkOutput("funct3_3_en", 32'(a1_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
